// File: rtl/sdram_test_master.sv
// sdram_test_master: Avalon-MM memory test master. It writes a seeded pattern
// over a word range, reads it back with pipelined reads and compares each word.
// Ports: CLK/RST (async, active-high); start -> busy/done/pass/err_count/
// first_err_addr results; avm_* is the Avalon-MM master toward the SDRAM slave.
// Optional build macro SDRAM_TEST_STOP_ON_ERR_EN: stop at the first mismatch.
module sdram_test_master #(
  parameter int          ADDR_W    = 24,
  parameter int          DATA_W    = 16,
  parameter int          BASE_ADDR = 0,
  parameter int          NUM_WORDS = 1024,
  parameter int          MAX_PEND  = 4,
  parameter logic [15:0] SEED      = 16'hA5C3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  TOTAL = CNT_W'(NUM_WORDS);
  localparam logic [PEND_W-1:0] PMAX  = PEND_W'(MAX_PEND);

`ifdef SDRAM_TEST_STOP_ON_ERR_EN
  localparam logic STOP_EN = 1'b1;
`else
  localparam logic STOP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DRAIN, DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cmp_idx;
  logic [PEND_W-1:0] pending;
  logic [15:0]       err_q;
  logic [ADDR_W-1:0] first_q;
  logic              pass_q;
  logic              stopped;

  logic cmd_rd, cmd_wr;
  logic acc, rd_acc, last;
  logic rsp, rsp_dec, cmp_en, mism;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] i);
    logic [31:0] t;
    t = 32'(i);
    return DATA_W'(SEED ^ t[15:0] ^ t[31:16]);
  endfunction

  assign last    = (idx == LAST);
  assign acc     = (cmd_rd | cmd_wr) & ~avm_waitrequest;
  assign rd_acc  = cmd_rd & ~avm_waitrequest;
  assign rsp     = avm_readdatavalid &
                   ((state == READ) | (state == DRAIN));
  assign rsp_dec = rsp & (pending != '0);
  // after a stop, late responses only drain the pipe
  assign cmp_en  = rsp & ~stopped;
  assign mism    = cmp_en &
                   (avm_readdata != pat(cmp_idx[ADDR_W-1:0]));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cmd_wr   = 1'b0;
    cmd_rd   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = WRITE;
      end
      WRITE: begin
        busy   = 1'b1;
        cmd_wr = 1'b1;
        if (!avm_waitrequest && last) state_nx = READ;
      end
      READ: begin
        busy   = 1'b1;
        // registered pending: a same-cycle response frees no slot
        cmd_rd = (pending < PMAX) & ~stopped;
        if ((rd_acc && last) || (STOP_EN && mism))
          state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pending == '0 && (cmp_idx == TOTAL || stopped))
          state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx     <= '0;
      cmp_idx <= '0;
      pending <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
      stopped <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        idx     <= '0;
        cmp_idx <= '0;
        pending <= '0;
        err_q   <= '0;
        first_q <= '0;
        pass_q  <= 1'b0;
        stopped <= 1'b0;
      end
    end else begin
      if (acc) idx <= last ? '0 : idx + ADDR_W'(1);
      if (rd_acc && !rsp_dec)
        pending <= pending + PEND_W'(1);
      else if (!rd_acc && rsp_dec)
        pending <= pending - PEND_W'(1);
      if (cmp_en) cmp_idx <= cmp_idx + CNT_W'(1);
      if (mism) begin
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        if (err_q == 16'd0)
          first_q <= BASE + cmp_idx[ADDR_W-1:0];
        stopped <= STOP_EN;
      end
      // pass is valid in the same cycle done pulses
      if (state_nx == DONE) pass_q <= (err_q == 16'd0);
    end
  end

  assign avm_write      = cmd_wr;
  assign avm_read       = cmd_rd;
  assign avm_byteenable = 2'b11;
  assign avm_address    = (cmd_rd | cmd_wr) ? BASE + idx : '0;
  assign avm_writedata  = cmd_wr ? pat(idx) : '0;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign pass           = pass_q;

endmodule
